// File: rtl/tfe_flow_hash_gen.sv
// Pipelined CRC-16 flow hash over the 104-bit 5-tuple, with issue-history hazard spacing.
// Optional build macro SYMMETRIC_HASH_EN: orders the endpoints so both directions share one hash.
module tfe_flow_hash_gen #(
    parameter int          HAZ_WIN  = 4,
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [7:0]  i_proto,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_hash,
    output logic        o_hash_valid,
    output logic [15:0] o_stall_cnt
);

    // MSB-first, non-reflected CRC update over one 26-bit message slice
    function automatic logic [15:0] crc_fold26(input logic [15:0] crc, input logic [25:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 25; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [4:0]   r_v;
    logic [15:0]  r_crc [5];
    logic [103:0] r_msg [4];
    logic         r_out_valid;
    logic [15:0]  r_out_hash;
    logic [HAZ_WIN-1:0] r_hist_v;
    logic [15:0]  r_hist_h [HAZ_WIN];
    logic [15:0]  r_stall_cnt;

    logic [103:0] w_msg;
    logic         w_stall;
    logic         w_issue;

    // Build the hash message from the presented tuple
    always_comb begin
        w_msg = {i_src_ip, i_dst_ip, i_src_port, i_dst_port, i_proto};
`ifdef SYMMETRIC_HASH_EN
        if ({i_src_ip, i_src_port} > {i_dst_ip, i_dst_port}) begin
            w_msg = {i_dst_ip, i_src_ip, i_dst_port, i_src_port, i_proto};
        end else begin
            w_msg = {i_src_ip, i_dst_ip, i_src_port, i_dst_port, i_proto};
        end
`endif
    end

    // Hazard: S4 candidate matches any valid slot of the recent-issue history
    always_comb begin
        w_stall = 1'b0;
        for (int j = 0; j < HAZ_WIN; j++) begin
            w_stall = w_stall | (r_v[4] & r_hist_v[j] & (r_hist_h[j] == r_crc[4]));
        end
    end

    assign w_issue      = r_v[4] & ~w_stall;
    assign o_ready      = ~w_stall;
    assign o_hash       = r_out_hash;
    assign o_hash_valid = r_out_valid;
    assign o_stall_cnt  = r_stall_cnt;

    // Capture stage S0 and fold stages S1..S4; the whole pipe freezes on a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= 5'd0;
            for (int k = 0; k < 5; k++) begin
                r_crc[k] <= 16'd0;
            end
            for (int k = 0; k < 4; k++) begin
                r_msg[k] <= 104'd0;
            end
        end else if (!w_stall) begin
            r_v[0]   <= i_valid;
            r_crc[0] <= CRC_INIT;
            r_msg[0] <= w_msg;
            for (int k = 1; k < 5; k++) begin
                r_v[k]   <= r_v[k-1];
                r_crc[k] <= crc_fold26(r_crc[k-1], r_msg[k-1][103-26*(k-1) -: 26]);
            end
            for (int k = 1; k < 4; k++) begin
                r_msg[k] <= r_msg[k-1];
            end
        end
    end

    // Output register and issue history; history shifts every cycle, bubbles included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_hash  <= 16'd0;
            r_hist_v    <= '0;
            for (int j = 0; j < HAZ_WIN; j++) begin
                r_hist_h[j] <= 16'd0;
            end
        end else begin
            r_out_valid <= w_issue;
            if (w_issue) begin
                r_out_hash <= r_crc[4];
            end
            for (int j = HAZ_WIN - 1; j > 0; j--) begin
                r_hist_v[j] <= r_hist_v[j-1];
                r_hist_h[j] <= r_hist_h[j-1];
            end
            r_hist_v[0] <= w_issue;
            r_hist_h[0] <= r_crc[4];
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
